// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot / auto-reload interrupt,
// exposed on a word-addressed register port (CTRL, PRESET, COUNT).
module countdown_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic             pend;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;

  logic             ctrl_wr;
  logic             preset_wr;
  logic             count_load;
  logic             count_dec;
  logic             pend_set;
  logic             pend_clr;
  logic             en_clr;

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);

  always_comb begin
    state_next = state;
    count_load = 1'b0;
    count_dec  = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    en_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        // Ends the single-cycle auto-reload pulse; a one-shot PEND can never
        // reach LOAD because re-enabling takes a CTRL write, which clears it.
        count_load = 1'b1;
        pend_clr   = 1'b1;
        state_next = CNT;
      end
      CNT: begin
        if (!en)                 state_next = IDLE;
        else if (count != '0)    count_dec  = 1'b1;
        else                     state_next = INT;
      end
      INT: begin
        pend_set = 1'b1;
        if (mode == 2'd1) begin
          state_next = LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      mode   <= 2'd0;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      // A CPU CTRL write overrides the INT-driven EN clear on the same edge.
      if (ctrl_wr)     {im, mode, en} <= wdata[3:0];
      else if (en_clr) en <= 1'b0;

      if (preset_wr) preset <= wdata;

      if (count_load)     count <= preset;
      else if (count_dec) count <= count - WIDTH'(1);

      if (ctrl_wr || preset_wr) pend <= 1'b0;
      else if (pend_set)        pend <= 1'b1;
      else if (pend_clr)        pend <= 1'b0;
    end
  end

  assign irq = pend & im;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = {{(WIDTH-4){1'b0}}, im, mode, en};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: reset, one-shot, auto-reload, masking,
// zero/max presets, ignored writes and the CTRL-write / INT collision.
module tb_countdown_timer;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_tests;
  int unsigned n_fail;

  countdown_timer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  logic [31:0] v;
  logic [31:0] exp_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;

    // Reset held two cycles with random bus traffic
    for (int i = 0; i < 2; i++) begin
      we    = 1'b1;
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      @(posedge clk);
      #1;
    end
    we  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check($sformatf("reset_rd%0d", i), v, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // One-shot: PRESET=5, CTRL=EN|IM; irq rises 9 edges after the CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'b1001);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("os_irq_e%0d", k), {31'd0, irq}, (k == 9) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        exp_cnt = (k <= 7) ? 32'(7 - k) : 32'd0;
        rd(2'd2, v);
        check($sformatf("os_cnt_e%0d", k), v, exp_cnt);
      end
    end
    rd(2'd0, v);
    check("os_ctrl_after", v, 32'b1000);
    step(); step(); step();
    check("os_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd7);
    check("os_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=EN|MODE1|IM; pulses at E7, E13, E19, E25, E31
    wr(2'd1, 32'd3);
    wr(2'd0, 32'b1011);
    for (int k = 1; k <= 33; k++) begin
      step();
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
            (k >= 7 && ((k - 7) % 6) == 0) ? 32'd1 : 32'd0);
    end
    // Disable at E34: CNT still sees EN=1 and decrements 2->1, then freezes
    wr(2'd0, 32'b1010);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("ar_off_irq%0d", k), {31'd0, irq}, 32'd0);
    end
    rd(2'd2, v);
    check("ar_frozen_cnt", v, 32'd1);

    // Masked zero preset: PEND sets after 4 edges, irq stays low
    wr(2'd1, 32'd0);
    wr(2'd0, 32'b0001);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("mz_irq_e%0d", k), {31'd0, irq}, 32'd0);
    end
    rd(2'd0, v);
    check("mz_ctrl_en_clr", v, 32'd0);
    rd(2'd2, v);
    check("mz_cnt", v, 32'd0);
    wr(2'd0, 32'b1000);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mz_unmask_irq%0d", k), {31'd0, irq}, 32'd0);
    end

    // Max preset: COUNT = 0xFFFFFFFF at E2, so 0xFFFFFFF6 at E11
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'b0001);
    for (int k = 0; k < 11; k++) step();
    rd(2'd2, v);
    check("max_cnt_e11", v, 32'hFFFF_FFF6);
    // PRESET write mid-count leaves the running count alone
    wr(2'd1, 32'd2);
    rd(2'd2, v);
    check("mid_preset_cnt", v, 32'hFFFF_FFF5);
    wr(2'd0, 32'd0);
    step(); step();
    rd(2'd2, v);
    check("stop_cnt", v, 32'hFFFF_FFF4);
    // Next load uses the new preset of 2
    wr(2'd0, 32'b1001);
    step(); step();
    rd(2'd2, v);
    check("reload_cnt", v, 32'd2);
    for (int k = 3; k <= 6; k++) step();
    check("reload_irq_e6", {31'd0, irq}, 32'd1);

    // Write to COUNT address is ignored and does not clear PEND
    wr(2'd2, 32'h0000_0055);
    rd(2'd2, v);
    check("addr2_cnt", v, 32'd0);
    rd(2'd1, v);
    check("addr2_preset", v, 32'd2);
    check("addr2_irq", {31'd0, irq}, 32'd1);

    // Collision: CTRL write lands on the INT edge (E6 for PRESET=2)
    wr(2'd1, 32'd2);
    wr(2'd0, 32'b1001);
    for (int k = 1; k <= 5; k++) step();
    wr(2'd0, 32'b1001);
    rd(2'd0, v);
    check("col_ctrl", v, 32'b1001);
    check("col_irq", {31'd0, irq}, 32'd0);
    step(); step();
    rd(2'd2, v);
    check("col_fresh_cnt", v, 32'd2);
    check("col_irq_later", {31'd0, irq}, 32'd0);

    // Reset mid-count, with a simultaneous write that must lose
    step();
    rst   = 1'b1;
    we    = 1'b1;
    addr  = 2'd1;
    wdata = 32'h1234_5678;
    step();
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      check($sformatf("midrst_rd%0d", i), v, 32'd0);
    end
    check("midrst_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
